glut_stage_sequencer: RTL and testbench
=======================================

Name: glut_stage_sequencer

Overview:
- Programmable stage sequencer for one add_mul_block_x4 tile of the glut array.
- Holds a small stage table of per-stage routing/mode words and steps through it on a start command.
- For each stage it drives stage_start, block_en, input selects and output selects, then counts DATA_NUM consumed beats.
- After the beats it holds the stage for DRAIN_CYC cycles so the adder/multiplier pipelines flush, then advances to the next stage.

Parameters:
- DATA_NUM, 192, beats consumed per stage (1..1023).
- STAGE_NUM, 8, stage table depth (power of 2, max 8).
- DRAIN_CYC, 16, flush cycles after the last beat (1..255); must be at least the float add/mul latency plus 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  stage table write strobe.
- cfg_addr  in  3  stage table index.
- cfg_data  in  16  stage word. Fields: [1:0] block_en, [5:2] input_sel_a, [8:6] input_sel_b, [11:9] add_output_sel, [14:12] mul_output_sel, [15] last.
- start  in  1  begin sequence at stage 0 (pulse).
- abort  in  1  terminate sequence (pulse).
- beat_valid  in  1  one operand beat consumed by the tile this cycle.
- stage_start  out  1  to tile; high during RUN and DRAIN.
- block_en  out  2  to tile.
- input_sel_a  out  4  to tile.
- input_sel_b  out  3  to tile.
- add_output_sel  out  3  to tile.
- mul_output_sel  out  3  to tile.
- stage_idx  out  3  current stage.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err_overrun  out  1  sticky; beat_valid was seen outside RUN while busy.

Behaviour:
- Reset: every output is 0; FSM in IDLE. The stage table is reset to all zeros (block_en=0, last=0).
- Config writes:
  - Accepted only in IDLE.
  - cfg_we while busy is ignored; the table is unchanged.
- All tile-control outputs are registered.
- FSM states: IDLE, LOAD, RUN, DRAIN, NEXT, DONE.
  - IDLE: on start, go to LOAD. Set stage_idx=0 and clear err_overrun.
  - LOAD (1 cycle): register the table[stage_idx] fields onto the tile outputs. Go to RUN. stage_start=0.
  - RUN: stage_start=1 and config outputs are stable.
    - beat_cnt increments on each beat_valid.
    - On the beat where beat_cnt==DATA_NUM-1 and beat_valid=1: clear beat_cnt and go to DRAIN.
    - No timeout; RUN waits indefinitely for beats.
  - DRAIN: stage_start=1, config held.
    - drain_cnt counts DRAIN_CYC cycles from 0, then go to NEXT.
    - beat_valid here sets err_overrun; the beat is not counted.
  - NEXT (1 cycle): stage_start=0.
    - If last=1 or stage_idx==STAGE_NUM-1, go to DONE.
    - Otherwise stage_idx+1 and go to LOAD.
  - DONE (1 cycle): done=1, then go to IDLE. Tile outputs are zeroed on entry to IDLE.
- Latency:
  - start at cycle T gives LOAD at T+1 and first RUN cycle (stage_start=1) at T+2.
  - Between stages, stage_start is low for exactly 2 cycles (NEXT, LOAD).
- Stage time with beat_valid held high continuously: DATA_NUM + DRAIN_CYC cycles of stage_start=1.
- Simultaneous events:
  - abort has priority over everything; start while busy is ignored.
  - start and abort in the same IDLE cycle: stay IDLE.
- abort in any busy state: next cycle IDLE, all tile outputs 0, counters 0, no done pulse. err_overrun is retained.
- Async reset mid-sequence: immediate return to reset values. The stage table is also cleared.
- Counters:
  - beat_cnt is 10-bit and never exceeds DATA_NUM-1.
  - drain_cnt is 8-bit.
  - stage_idx wraps never; the sequence terminates at STAGE_NUM-1.

Test Plan:
- DATA_NUM=4, DRAIN_CYC=3. Write stage0=16'h800D (block_en=01, sel_a=0011, last=1). Pulse start at T, beat_valid continuously high from T+2.
  - Expect block_en=01 and sel_a=0011 from T+2.
  - Expect stage_start high T+2..T+8 (7 cycles).
  - Expect done at T+10 and busy low at T+11.
- Three stages with last on stage2, each with distinct words.
  - Expect outputs to change only in LOAD cycles.
  - Expect stage_idx to go 0,1,2.
  - Expect a 2-cycle stage_start gap between stages and exactly one done.
- Gapped beats: beat_valid every other cycle with DATA_NUM=4 → RUN lasts 8 cycles. Then pulse beat_valid during DRAIN → err_overrun=1, stays high until the next start.
- Abort in the 2nd cycle of RUN of stage1 → next cycle all outputs 0, busy=0, no done. A subsequent start restarts at stage 0.
- Write attempts: cfg_we during RUN with a different word → a later sequence still uses the original word. start pulsed during RUN → no effect on stage_idx.
- rst_n asserted asynchronously mid-DRAIN → outputs 0 immediately without a clock edge. The table is cleared, so a re-run with no writes drives block_en=00 and stops after stage 7 (STAGE_NUM-1).

Source files
------------

// File: rtl/glut_stage_sequencer_if.sv
`default_nettype none
// ============================================================
// Module  : glut_stage_sequencer_if
// Purpose : command, config and tile-control bundle of the sequencer
// Revision: 1.0 - initial release
// ============================================================
interface glut_stage_sequencer_if;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start;
  logic        abort;
  logic        beat_valid;
  logic        stage_start;
  logic [1:0]  block_en;
  logic [3:0]  input_sel_a;
  logic [2:0]  input_sel_b;
  logic [2:0]  add_output_sel;
  logic [2:0]  mul_output_sel;
  logic [2:0]  stage_idx;
  logic        busy;
  logic        done;
  logic        err_overrun;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, abort, beat_valid,
    input  stage_start, block_en, input_sel_a, input_sel_b,
           add_output_sel, mul_output_sel, stage_idx, busy, done, err_overrun
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, abort, beat_valid,
    output stage_start, block_en, input_sel_a, input_sel_b,
           add_output_sel, mul_output_sel, stage_idx, busy, done, err_overrun
  );
endinterface
`default_nettype wire

// File: rtl/glut_stage_sequencer.sv
`default_nettype none
// ============================================================
// Module  : glut_stage_sequencer
// Purpose : steps an add_mul_block_x4 tile through a stage table
// Revision: 1.0 - initial release
// ============================================================
module glut_stage_sequencer #(
  parameter int DATA_NUM  = 192,
  parameter int STAGE_NUM = 8,
  parameter int DRAIN_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  glut_stage_sequencer_if.slave seq_if
);
  localparam int         c_IDX_W      = $clog2(STAGE_NUM);
  localparam logic [9:0] c_BEAT_LAST  = 10'(DATA_NUM - 1);
  localparam logic [7:0] c_DRAIN_LAST = 8'(DRAIN_CYC - 1);
  localparam logic [2:0] c_LAST_IDX   = 3'(STAGE_NUM - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_NEXT  = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]  r_state, w_next_state;
  logic [9:0]  r_beat_cnt;
  logic [7:0]  r_drain_cnt;
  logic [15:0] r_table [STAGE_NUM];
  logic [15:0] w_tbl_word;
  logic        w_beat_end, w_drain_end;

  // Tile word held as {mul, add, sel_b, sel_a, block_en}, matching the table layout.
  logic [14:0] r_word, w_word;
  logic        r_last, w_last;
  logic [2:0]  r_stage_idx, w_stage_idx;
  logic        r_stage_start, w_stage_start;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_err_overrun, w_err;

  assign w_tbl_word  = r_table[r_stage_idx[c_IDX_W-1:0]];
  assign w_beat_end  = (r_state == c_RUN) && seq_if.beat_valid && (r_beat_cnt == c_BEAT_LAST);
  assign w_drain_end = (r_state == c_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (seq_if.abort) begin
      w_next_state = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (seq_if.start) w_next_state = c_LOAD;
        c_LOAD:  w_next_state = c_RUN;
        c_RUN:   if (w_beat_end) w_next_state = c_DRAIN;
        c_DRAIN: if (w_drain_end) w_next_state = c_NEXT;
        c_NEXT:  w_next_state = (r_last || (r_stage_idx == c_LAST_IDX)) ? c_DONE : c_LOAD;
        c_DONE:  w_next_state = c_IDLE;
        default: w_next_state = c_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    w_stage_start = (w_next_state == c_RUN) || (w_next_state == c_DRAIN);
    w_busy        = (w_next_state != c_IDLE);
    w_done        = (w_next_state == c_DONE);
    w_word        = r_word;
    w_last        = r_last;
    w_stage_idx   = r_stage_idx;
    w_err         = r_err_overrun;
    if (w_next_state == c_IDLE) begin
      w_word      = '0;
      w_last      = 1'b0;
      w_stage_idx = '0;
    end else if (r_state == c_LOAD) begin
      w_word = w_tbl_word[14:0];
      w_last = w_tbl_word[15];
    end else if (r_state == c_IDLE) begin
      w_stage_idx = '0;
    end else if ((r_state == c_NEXT) && (w_next_state == c_LOAD)) begin
      w_stage_idx = r_stage_idx + 3'd1;
    end
    if ((r_state == c_IDLE) && seq_if.start && !seq_if.abort) begin
      w_err = 1'b0;
    end else if ((r_state != c_IDLE) && (r_state != c_RUN) && seq_if.beat_valid) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word        <= '0;
      r_last        <= 1'b0;
      r_stage_idx   <= '0;
      r_stage_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_word        <= w_word;
      r_last        <= w_last;
      r_stage_idx   <= w_stage_idx;
      r_stage_start <= w_stage_start;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_err_overrun <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if ((r_state == c_RUN) && (w_next_state == c_RUN) && seq_if.beat_valid) begin
        r_beat_cnt <= r_beat_cnt + 10'd1;
      end else if (w_next_state != c_RUN) begin
        r_beat_cnt <= '0;
      end
      r_drain_cnt <= ((r_state == c_DRAIN) && (w_next_state == c_DRAIN)) ? r_drain_cnt + 8'd1 : '0;
    end
  end

  // The table only takes writes while the sequence is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGE_NUM; i++) begin
        r_table[i] <= '0;
      end
    end else if (seq_if.cfg_we && (r_state == c_IDLE) && (int'(seq_if.cfg_addr) < STAGE_NUM)) begin
      r_table[seq_if.cfg_addr[c_IDX_W-1:0]] <= seq_if.cfg_data;
    end
  end

  assign seq_if.stage_start    = r_stage_start;
  assign seq_if.block_en       = r_word[1:0];
  assign seq_if.input_sel_a    = r_word[5:2];
  assign seq_if.input_sel_b    = r_word[8:6];
  assign seq_if.add_output_sel = r_word[11:9];
  assign seq_if.mul_output_sel = r_word[14:12];
  assign seq_if.stage_idx      = r_stage_idx;
  assign seq_if.busy           = r_busy;
  assign seq_if.done           = r_done;
  assign seq_if.err_overrun    = r_err_overrun;
endmodule
`default_nettype wire

// File: tb/tb_glut_stage_sequencer.sv
`default_nettype none
// ============================================================
// Module  : tb_glut_stage_sequencer
// Purpose : directed checks of glut_stage_sequencer, DATA_NUM=4 DRAIN_CYC=3
// Revision: 1.0 - initial release
// ============================================================
module tb_glut_stage_sequencer;
  localparam int c_DATA_NUM  = 4;
  localparam int c_DRAIN_CYC = 3;
  localparam int c_STAGE_NUM = 8;
  localparam int c_PER       = c_DATA_NUM + c_DRAIN_CYC + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_tbl [8];
  logic [20:0] obs;
  logic [20:0] e;

  glut_stage_sequencer_if sif ();

  glut_stage_sequencer #(
    .DATA_NUM (c_DATA_NUM),
    .STAGE_NUM(c_STAGE_NUM),
    .DRAIN_CYC(c_DRAIN_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(sif)
  );

  always #5 clk = ~clk;

  assign obs = {sif.stage_start, sif.busy, sif.done, sif.stage_idx, sif.mul_output_sel,
                sif.add_output_sel, sif.input_sel_b, sif.input_sel_a, sif.block_en};

  // Expected {stage_start, busy, done, stage_idx, word[14:0]} k cycles after start,
  // with every stage taking LOAD + beats + drain + NEXT and nst stages in total.
  function automatic logic [20:0] exp_vec(int k, int nst);
    int s;
    int p;
    logic [15:0] w;
    if (k >= 1 && k <= nst * c_PER) begin
      s = (k - 1) / c_PER;
      p = (k - 1) % c_PER;
      w = (p == 0) ? ((s == 0) ? 16'h0000 : exp_tbl[s-1]) : exp_tbl[s];
      return {(p >= 1 && p <= c_PER - 2), 1'b1, 1'b0, 3'(s), w[14:0]};
    end else if (k == nst * c_PER + 1) begin
      w = exp_tbl[nst-1];
      return {1'b0, 1'b1, 1'b1, 3'(nst - 1), w[14:0]};
    end
    return '0;
  endfunction

  function automatic logic is_run(int k, int nst);
    int p;
    p = (k - 1) % c_PER;
    return (k >= 1) && (k <= nst * c_PER) && (p >= 1) && (p <= c_DATA_NUM);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    sif.cfg_we   = 1'b1;
    sif.cfg_addr = a;
    sif.cfg_data = d;
    tick();
    sif.cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
    end
    checks++;
    if (sif.err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", sif.err_overrun);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, 21'h0);
    end
  endtask

  task automatic test_single_stage();
    exp_tbl[0] = 16'h800D;
    cfg_write(3'd0, 16'h800D);
    sif.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = (k >= 2);
      e = exp_vec(k, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_obs k=%0d: got %h expected %h", k, obs, e);
      end
      checks++;
      if (sif.err_overrun !== (k >= 7)) begin
        errors++;
        $display("FAIL single_err k=%0d: got %b expected %b", k, sif.err_overrun, (k >= 7));
      end
    end
    sif.beat_valid = 1'b0;
  endtask

  task automatic test_multi_stage();
    int ndone;
    ndone = 0;
    exp_tbl[0] = 16'h3456;
    exp_tbl[1] = 16'h4BAB;
    exp_tbl[2] = 16'hF1FD;
    cfg_write(3'd0, 16'h3456);
    cfg_write(3'd1, 16'h4BAB);
    cfg_write(3'd2, 16'hF1FD);
    sif.start = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = is_run(k, 3);
      e = exp_vec(k, 3);
      ndone += int'(sif.done);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL multi_obs k=%0d: got %h expected %h", k, obs, e);
      end
      checks++;
      if (sif.err_overrun !== 1'b0) begin
        errors++;
        $display("FAIL multi_err k=%0d: got %b expected 0", k, sif.err_overrun);
      end
    end
    sif.beat_valid = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL multi_done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_gapped_overrun();
    exp_tbl[0] = 16'h8001;
    cfg_write(3'd0, 16'h8001);
    sif.start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = (k == 3) || (k == 5) || (k == 7) || (k == 9) || (k == 11);
      if (k == 1)                e = {1'b0, 1'b1, 1'b0, 3'd0, 15'h0000};
      else if (k <= 12)          e = {1'b1, 1'b1, 1'b0, 3'd0, 15'h0001};
      else if (k == 13)          e = {1'b0, 1'b1, 1'b0, 3'd0, 15'h0001};
      else if (k == 14)          e = {1'b0, 1'b1, 1'b1, 3'd0, 15'h0001};
      else                       e = '0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL gapped_obs k=%0d: got %h expected %h", k, obs, e);
      end
      checks++;
      if (sif.err_overrun !== (k >= 12)) begin
        errors++;
        $display("FAIL gapped_err k=%0d: got %b expected %b", k, sif.err_overrun, (k >= 12));
      end
    end
    sif.beat_valid = 1'b0;
  endtask

  task automatic test_abort();
    exp_tbl[0] = 16'h3456;
    exp_tbl[1] = 16'h4BAB;
    exp_tbl[2] = 16'hF1FD;
    cfg_write(3'd0, 16'h3456);
    cfg_write(3'd1, 16'h4BAB);
    checks++;
    if (sif.err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL abort_err_kept_idle: got %b expected 1", sif.err_overrun);
    end
    sif.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = is_run(k, 3) && (k <= 12);
      sif.abort      = (k == 12);
      e = (k <= 12) ? exp_vec(k, 3) : 21'h0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_obs k=%0d: got %h expected %h", k, obs, e);
      end
      checks++;
      if (sif.err_overrun !== 1'b0) begin
        errors++;
        $display("FAIL abort_err k=%0d: got %b expected 0", k, sif.err_overrun);
      end
    end
    sif.abort = 1'b0;
    sif.beat_valid = 1'b0;
    sif.start = 1'b1;
    sif.abort = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    tick();
    checks++;
    if (obs !== 21'h0) begin
      errors++;
      $display("FAIL abort_start_same_cycle: got %h expected %h", obs, 21'h0);
    end
    sif.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      sif.start = 1'b0;
      sif.abort = (k == 2);
      e = (k <= 2) ? exp_vec(k, 3) : 21'h0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_restart k=%0d: got %h expected %h", k, obs, e);
      end
    end
    sif.abort = 1'b0;
    tick();
  endtask

  task automatic test_write_protect();
    exp_tbl[0] = 16'h800D;
    cfg_write(3'd0, 16'h800D);
    sif.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      sif.start      = (k == 4);
      sif.cfg_we     = (k == 3);
      sif.cfg_addr   = 3'd0;
      sif.cfg_data   = 16'h0002;
      sif.beat_valid = is_run(k, 1);
      e = exp_vec(k, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wprot_obs k=%0d: got %h expected %h", k, obs, e);
      end
    end
    sif.beat_valid = 1'b0;
    sif.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      sif.start = 1'b0;
      sif.abort = (k == 2);
      e = (k <= 2) ? exp_vec(k, 1) : 21'h0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wprot_rerun k=%0d: got %h expected %h", k, obs, e);
      end
    end
    sif.abort = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    exp_tbl[0] = 16'h3456;
    exp_tbl[1] = 16'h4BAB;
    cfg_write(3'd0, 16'h3456);
    sif.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = is_run(k, 2) || (k == 6);
      e = exp_vec(k, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_pre k=%0d: got %h expected %h", k, obs, e);
      end
    end
    sif.beat_valid = 1'b0;
    checks++;
    if (sif.err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL areset_err_before: got %b expected 1", sif.err_overrun);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 21'h0 || sif.err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got %h/%b expected %h/0", obs, sif.err_overrun, 21'h0);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_tbl[i] = 16'h0000;
    tick();
    sif.start = 1'b1;
    for (int k = 1; k <= 76; k++) begin
      tick();
      sif.start      = 1'b0;
      sif.beat_valid = is_run(k, 8);
      e = exp_vec(k, 8);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_rerun k=%0d: got %h expected %h", k, obs, e);
      end
    end
    sif.beat_valid = 1'b0;
  endtask

  initial begin
    sif.cfg_we     = 1'b0;
    sif.cfg_addr   = 3'd0;
    sif.cfg_data   = 16'h0000;
    sif.start      = 1'b0;
    sif.abort      = 1'b0;
    sif.beat_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_tbl[i] = 16'h0000;
    test_reset();
    test_single_stage();
    test_multi_stage();
    test_gapped_overrun();
    test_abort();
    test_write_protect();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
